// File: rtl/hoeraa_pipe_adder.sv
// Two-stage valid/ready pipelined HOERAA approximate adder. The approximate width is selectable per beat.
// An on-chip statistics unit counts erroneous beats and tracks the worst-case error distance.
module hoeraa_pipe_adder #(
    parameter int unsigned N     = 16,
    parameter int unsigned K_MAX = 8,
    parameter int unsigned KW    = $clog2(K_MAX + 1),
    parameter int unsigned CW    = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_x,
    input  logic [N-1:0]  in_y,
    input  logic [KW-1:0] in_k,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_s,
    output logic          out_co,
    output logic          out_err,
    input  logic          stat_clr,
    output logic [CW-1:0] err_cnt,
    output logic [CW-1:0] beat_cnt,
    output logic [N:0]    err_max
);

    logic          r_s1_valid;
    logic [N-1:0]  r_x;
    logic [N-1:0]  r_y;
    logic [KW-1:0] r_ke;

    logic          r_s2_valid;
    logic [N-1:0]  r_s;
    logic          r_co;
    logic          r_err;
    logic [N:0]    r_d;

    logic [CW-1:0] r_err_cnt;
    logic [CW-1:0] r_beat_cnt;
    logic [N:0]    r_err_max;

    logic          w_s1_adv;
    logic          w_s2_adv;
    logic          w_out_hs;
    logic [KW-1:0] w_ke_in;
    int            w_ke;
    logic          w_c;
    logic          w_p;
    logic [N:0]    w_exact;
    logic [N:0]    w_hi;
    logic [N:0]    w_lo;
    logic [N:0]    w_approx;
    logic [N:0]    w_dist;

    assign w_s2_adv = !r_s2_valid || out_ready;
    assign w_s1_adv = !r_s1_valid || w_s2_adv;
    assign w_out_hs = r_s2_valid && out_ready;
    assign in_ready = w_s1_adv;
    assign w_ke_in  = (in_k > KW'(K_MAX)) ? KW'(K_MAX) : in_k;

    // Approximate sum of the stage-1 operands, the exact reference and the error distance
    always_comb begin
        w_ke     = int'(r_ke);
        w_exact  = {1'b0, r_x} + {1'b0, r_y};
        w_c      = 1'b0;
        w_p      = 1'b0;
        w_lo     = '0;
        w_approx = w_exact;
        for (int i = 0; i < N; i++) begin
            if (i == w_ke - 1) w_c = r_x[i] & r_y[i];
            if (i == w_ke - 2) w_p = r_x[i] & r_y[i];
        end
        for (int i = 0; i < N; i++) begin
            if (i < w_ke - 1)
                w_lo[i] = r_x[i] | r_y[i] | w_c;
            else if (i == w_ke - 1)
                w_lo[i] = (r_x[i] ^ r_y[i]) | w_p;
        end
        // Exact upper part aligned back to bit ke; its low ke bits are zero
        w_hi = ((({1'b0, r_x} >> r_ke) + ({1'b0, r_y} >> r_ke) + {{N{1'b0}}, w_c}) << r_ke);
        if (w_ke >= 2)
            w_approx = w_hi | w_lo;
        w_dist = (w_exact >= w_approx) ? (w_exact - w_approx) : (w_approx - w_exact);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_x        <= '0;
            r_y        <= '0;
            r_ke       <= '0;
            r_s2_valid <= 1'b0;
            r_s        <= '0;
            r_co       <= 1'b0;
            r_err      <= 1'b0;
            r_d        <= '0;
        end else begin
            if (w_s1_adv) begin
                r_s1_valid <= in_valid;
                if (in_valid) begin
                    r_x  <= in_x;
                    r_y  <= in_y;
                    r_ke <= w_ke_in;
                end
            end
            if (w_s2_adv) begin
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_s   <= w_approx[N-1:0];
                    r_co  <= w_approx[N];
                    r_err <= (w_approx != w_exact);
                    r_d   <= w_dist;
                end
            end
        end
    end

    // Statistics: a clear takes priority over a coincident output handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_cnt  <= '0;
            r_beat_cnt <= '0;
            r_err_max  <= '0;
        end else if (stat_clr) begin
            r_err_cnt  <= '0;
            r_beat_cnt <= '0;
            r_err_max  <= '0;
        end else if (w_out_hs) begin
            if (r_beat_cnt != '1)
                r_beat_cnt <= r_beat_cnt + CW'(1);
            if (r_err && (r_err_cnt != '1))
                r_err_cnt <= r_err_cnt + CW'(1);
            if (r_d > r_err_max)
                r_err_max <= r_d;
        end
    end

    assign out_valid = r_s2_valid;
    assign out_s     = r_s;
    assign out_co    = r_co;
    assign out_err   = r_err;
    assign err_cnt   = r_err_cnt;
    assign beat_cnt  = r_beat_cnt;
    assign err_max   = r_err_max;

endmodule

// File: tb/tb_hoeraa_pipe_adder.sv
// Directed bench for hoeraa_pipe_adder: approximate/exact results, latency, backpressure,
// statistics, stat_clr priority and asynchronous reset with beats in flight.
module tb_hoeraa_pipe_adder;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_x;
    logic [15:0] in_y;
    logic [3:0]  in_k;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_s;
    logic        out_co;
    logic        out_err;
    logic        stat_clr;
    logic [15:0] err_cnt;
    logic [15:0] beat_cnt;
    logic [16:0] err_max;

    int pass_cnt = 0;
    int total_cnt = 0;

    hoeraa_pipe_adder #(.N(16), .K_MAX(8), .KW(4), .CW(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_y      (in_y),
        .in_k      (in_k),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_s     (out_s),
        .out_co    (out_co),
        .out_err   (out_err),
        .stat_clr  (stat_clr),
        .err_cnt   (err_cnt),
        .beat_cnt  (beat_cnt),
        .err_max   (err_max)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sends one beat into an empty pipeline and returns {co, err, s} plus the cycle it appeared in
    task automatic send_one(input logic [15:0] x, input logic [15:0] y, input logic [3:0] k,
                            output logic [17:0] res, output int cyc);
        in_valid  = 1'b1;
        in_x      = x;
        in_y      = y;
        in_k      = k;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        cyc = 1;
        while (!out_valid && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        res = {out_co, out_err, out_s};
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_x = '0; in_y = '0; in_k = '0;
        out_ready = 1'b0; stat_clr = 1'b0;
        #12;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid); else pass_cnt++;
        total_cnt++; if ({out_co, out_err, out_s} !== 18'h0) $display("FAIL reset_outputs: got %h expected 0", {out_co, out_err, out_s}); else pass_cnt++;
        total_cnt++; if ({err_cnt, beat_cnt} !== 32'h0) $display("FAIL reset_counters: got %h expected 0", {err_cnt, beat_cnt}); else pass_cnt++;
        total_cnt++; if (err_max !== 17'h0) $display("FAIL reset_err_max: got %h expected 0", err_max); else pass_cnt++;
        rst_n = 1'b1;
        @(negedge clk);
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready); else pass_cnt++;
    endtask

    task automatic test_approx();
        logic [17:0] res;
        int cyc;
        send_one(16'h0001, 16'h0001, 4'd6, res, cyc);
        total_cnt++; if (res !== {1'b0, 1'b1, 16'h0001}) $display("FAIL approx_v1: got %h expected %h", res, {1'b0, 1'b1, 16'h0001}); else pass_cnt++;
        total_cnt++; if (cyc !== 2) $display("FAIL approx_v1_latency: got %0d expected 2", cyc); else pass_cnt++;
        send_one(16'h00FF, 16'h00FF, 4'd6, res, cyc);
        total_cnt++; if (res !== {1'b0, 1'b1, 16'h01FF}) $display("FAIL approx_v2: got %h expected %h", res, {1'b0, 1'b1, 16'h01FF}); else pass_cnt++;
        total_cnt++; if (err_cnt !== 16'd2) $display("FAIL stats_err_cnt_2: got %0d expected 2", err_cnt); else pass_cnt++;
        total_cnt++; if (err_max !== 17'd1) $display("FAIL stats_err_max_2: got %0d expected 1", err_max); else pass_cnt++;
        total_cnt++; if (beat_cnt !== 16'd2) $display("FAIL stats_beat_cnt_2: got %0d expected 2", beat_cnt); else pass_cnt++;
        send_one(16'hFFFF, 16'hFFFF, 4'd6, res, cyc);
        total_cnt++; if (res !== {1'b1, 1'b1, 16'hFFFF}) $display("FAIL approx_v3: got %h expected %h", res, {1'b1, 1'b1, 16'hFFFF}); else pass_cnt++;
    endtask

    task automatic test_exact();
        logic [17:0] res;
        int cyc;
        send_one(16'hFFFF, 16'hFFFF, 4'd0, res, cyc);
        total_cnt++; if (res !== {1'b1, 1'b0, 16'hFFFE}) $display("FAIL exact_k0: got %h expected %h", res, {1'b1, 1'b0, 16'hFFFE}); else pass_cnt++;
        send_one(16'h5555, 16'hAAAA, 4'd15, res, cyc);
        total_cnt++; if (res !== {1'b0, 1'b0, 16'hFFFF}) $display("FAIL clamp_k15: got %h expected %h", res, {1'b0, 1'b0, 16'hFFFF}); else pass_cnt++;
        send_one(16'h1234, 16'h4321, 4'd1, res, cyc);
        total_cnt++; if (res !== {1'b0, 1'b0, 16'h5555}) $display("FAIL exact_k1: got %h expected %h", res, {1'b0, 1'b0, 16'h5555}); else pass_cnt++;
        total_cnt++; if ({err_cnt, beat_cnt} !== {16'd3, 16'd6}) $display("FAIL stats_after_exact: got %h expected %h", {err_cnt, beat_cnt}, {16'd3, 16'd6}); else pass_cnt++;
        total_cnt++; if (err_max !== 17'd1) $display("FAIL stats_err_max_6: got %0d expected 1", err_max); else pass_cnt++;
    endtask

    task automatic test_stat_clr();
        out_ready = 1'b0;
        in_valid = 1'b1; in_x = 16'h0001; in_y = 16'h0001; in_k = 4'd6;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        total_cnt++; if (out_valid !== 1'b1) $display("FAIL clr_out_valid: got %b expected 1", out_valid); else pass_cnt++;
        out_ready = 1'b1;
        stat_clr  = 1'b1;
        @(negedge clk);
        stat_clr = 1'b0;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL clr_beat_consumed: got %b expected 0", out_valid); else pass_cnt++;
        total_cnt++; if ({err_cnt, beat_cnt} !== 32'h0) $display("FAIL clr_counters: got %h expected 0", {err_cnt, beat_cnt}); else pass_cnt++;
        total_cnt++; if (err_max !== 17'h0) $display("FAIL clr_err_max: got %h expected 0", err_max); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [15:0] ex [8] = '{16'h1112, 16'h2223, 16'h3334, 16'h4445,
                                16'h5556, 16'h6667, 16'h7778, 16'h8889};
        logic [15:0] held_s;
        logic        held;
        logic        saw_full;
        logic        acc;
        int snd;
        int rcv;
        int cyc;
        snd = 0; rcv = 0; cyc = 0; held = 1'b0; saw_full = 1'b0; held_s = '0;
        in_k = 4'd0; in_y = 16'h0001;
        while (rcv < 8 && cyc < 60) begin
            out_ready = !(cyc >= 4 && cyc < 7);
            in_valid  = (snd < 8);
            in_x      = 16'h1111 * 16'(snd + 1);
            #1;
            if (!in_ready) saw_full = 1'b1;
            if (out_valid) begin
                if (held) begin
                    total_cnt++; if (out_s !== held_s) $display("FAIL b2b_stall_hold: got %h expected %h", out_s, held_s); else pass_cnt++;
                end
                if (out_ready) begin
                    total_cnt++; if (out_s !== ex[rcv]) $display("FAIL b2b_beat%0d: got %h expected %h", rcv, out_s, ex[rcv]); else pass_cnt++;
                    rcv++;
                    held = 1'b0;
                end else begin
                    held   = 1'b1;
                    held_s = out_s;
                end
            end
            acc = in_valid && in_ready;
            @(posedge clk);
            if (acc) snd++;
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        total_cnt++; if (rcv !== 8) $display("FAIL b2b_delivered: got %0d expected 8", rcv); else pass_cnt++;
        total_cnt++; if (saw_full !== 1'b1) $display("FAIL b2b_in_ready_drop: got %b expected 1", saw_full); else pass_cnt++;
        @(negedge clk);
        @(negedge clk);
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL b2b_no_duplicate: got %b expected 0", out_valid); else pass_cnt++;
        total_cnt++; if (beat_cnt !== 16'd8) $display("FAIL b2b_beat_cnt: got %0d expected 8", beat_cnt); else pass_cnt++;
    endtask

    task automatic test_reset_midflight();
        logic [17:0] res;
        int cyc;
        out_ready = 1'b0;
        in_valid = 1'b1; in_x = 16'h1234; in_y = 16'h1111; in_k = 4'd0;
        @(posedge clk);
        @(negedge clk);
        in_x = 16'h0F0F; in_y = 16'h0101;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL rst_mid_out_valid: got %b expected 0", out_valid); else pass_cnt++;
        total_cnt++; if (out_s !== 16'h0) $display("FAIL rst_mid_out_s: got %h expected 0", out_s); else pass_cnt++;
        total_cnt++; if (beat_cnt !== 16'h0) $display("FAIL rst_mid_beat_cnt: got %0d expected 0", beat_cnt); else pass_cnt++;
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL rst_mid_discard: got %b expected 0", out_valid); else pass_cnt++;
        send_one(16'h0001, 16'h0001, 4'd6, res, cyc);
        total_cnt++; if (res !== {1'b0, 1'b1, 16'h0001}) $display("FAIL rst_post_result: got %h expected %h", res, {1'b0, 1'b1, 16'h0001}); else pass_cnt++;
        total_cnt++; if (cyc !== 2) $display("FAIL rst_post_latency: got %0d expected 2", cyc); else pass_cnt++;
        total_cnt++; if ({err_cnt, beat_cnt} !== {16'd1, 16'd1}) $display("FAIL rst_post_counters: got %h expected %h", {err_cnt, beat_cnt}, {16'd1, 16'd1}); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_approx();
        test_exact();
        test_stat_clr();
        test_back_to_back();
        test_reset_midflight();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
